// File: rtl/ex_hilo_muldiv_pkg.sv
// Shared types and helpers for the EX-stage multiply/divide unit and its HI/LO registers.
package ex_hilo_muldiv_pkg;

    localparam int WORD_W    = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } state_t;

    // The magnitude of 0x80000000 is 0x80000000 when the result is read as unsigned.
    function automatic logic [WORD_W-1:0] abs32(input logic signed [WORD_W-1:0] v);
        return v[WORD_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes, one quotient bit per step.
module ex_div_iter
    import ex_hilo_muldiv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [WORD_W-1:0] dividend,
    input  logic [WORD_W-1:0] divisor,
    output logic [WORD_W-1:0] q,
    output logic [WORD_W-1:0] r,
    output logic              last
);

    logic [WORD_W-1:0] rem_q;
    logic [WORD_W-1:0] quo_q;
    logic [WORD_W-1:0] dvs_q;
    logic [4:0]        cnt_q;
    logic [WORD_W:0]   rem_sh;
    logic [WORD_W:0]   diff;

    // The quotient register starts as the dividend and its MSB is shifted into the remainder.
    always_comb begin
        rem_sh = {rem_q, quo_q[WORD_W-1]};
        diff   = rem_sh - {1'b0, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= '0;
        end else if (step) begin
            if (!diff[WORD_W]) begin
                rem_q <= diff[WORD_W-1:0];
                quo_q <= {quo_q[WORD_W-2:0], 1'b1};
            end else begin
                rem_q <= rem_sh[WORD_W-1:0];
                quo_q <= {quo_q[WORD_W-2:0], 1'b0};
            end
            cnt_q <= cnt_q + 5'd1;
        end
    end

    assign q    = quo_q;
    assign r    = rem_q;
    assign last = (cnt_q == 5'(DIV_STEPS - 1));

endmodule

// File: rtl/ex_hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MUL unit with architectural HI/LO and MTHI/MTLO support.
module ex_hilo_muldiv
    import ex_hilo_muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 2
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_mul,
    input  logic              op_div,
    input  logic              op_signed,
    input  logic              hilo_wen,
    input  logic [WORD_W-1:0] src_a,
    input  logic [WORD_W-1:0] src_b,
    input  logic              mthi,
    input  logic              mtlo,
    input  logic [WORD_W-1:0] mv_data,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] res_hi,
    output logic [WORD_W-1:0] res_lo,
    output logic [WORD_W-1:0] hi,
    output logic [WORD_W-1:0] lo
);

    state_t                   state_q;
    logic [1:0]               cnt_q;
    logic [WORD_W-1:0]        a_q;
    logic [WORD_W-1:0]        b_q;
    logic                     sgn_q;
    logic                     wen_q;
    logic                     is_div_q;
    logic [2*WORD_W-1:0]      prod_q;
    logic signed [2*WORD_W-1:0] a_ext;
    logic signed [2*WORD_W-1:0] b_ext;
    logic signed [2*WORD_W-1:0] prod;
    logic                     accept;
    logic                     in_fin;
    logic                     neg_a;
    logic                     neg_b;
    logic [WORD_W-1:0]        div_q;
    logic [WORD_W-1:0]        div_r;
    logic [WORD_W-1:0]        q_fix;
    logic [WORD_W-1:0]        r_fix;
    logic                     div_last;
    logic [WORD_W-1:0]        dvd_in;
    logic [WORD_W-1:0]        dvs_in;

    assign accept = (state_q == ST_IDLE) & start & (op_mul | op_div) & ~flush & ~mthi & ~mtlo;
    assign in_fin = (state_q == ST_FIN);

    // Extending to 64 bits before multiplying keeps the low 64 product bits exact for both signednesses.
    assign a_ext = {{WORD_W{sgn_q & a_q[WORD_W-1]}}, a_q};
    assign b_ext = {{WORD_W{sgn_q & b_q[WORD_W-1]}}, b_q};
    assign prod  = a_ext * b_ext;

    assign dvd_in = op_signed ? abs32(src_a) : src_a;
    assign dvs_in = op_signed ? abs32(src_b) : src_b;

    ex_div_iter u_div (
        .clk      (clk),
        .rst      (rst),
        .load     (accept & op_div),
        .step     ((state_q == ST_DIV) & ~flush),
        .dividend (dvd_in),
        .divisor  (dvs_in),
        .q        (div_q),
        .r        (div_r),
        .last     (div_last)
    );

    assign neg_a = sgn_q & a_q[WORD_W-1];
    assign neg_b = sgn_q & b_q[WORD_W-1];
    assign q_fix = (neg_a ^ neg_b) ? -div_q : div_q;
    assign r_fix = neg_a ? -div_r : div_r;

    assign res_hi = in_fin ? (is_div_q ? r_fix : prod_q[2*WORD_W-1:WORD_W]) : '0;
    assign res_lo = in_fin ? (is_div_q ? q_fix : prod_q[WORD_W-1:0])        : '0;
    assign done   = in_fin & ~flush;
    assign busy   = accept | (state_q == ST_MUL) | (state_q == ST_DIV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sgn_q    <= 1'b0;
            wen_q    <= 1'b0;
            is_div_q <= 1'b0;
            prod_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    a_q      <= src_a;
                    b_q      <= src_b;
                    sgn_q    <= op_signed;
                    wen_q    <= hilo_wen;
                    is_div_q <= op_div;
                    cnt_q    <= 2'(MUL_CYCLES - 1);
                    state_q  <= op_div ? ST_DIV : ST_MUL;
                end
                ST_MUL: if (flush) begin
                    state_q <= ST_IDLE;
                end else if (cnt_q == 2'd0) begin
                    prod_q  <= prod;
                    state_q <= ST_FIN;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
                ST_DIV: if (flush) begin
                    state_q <= ST_IDLE;
                end else if (div_last) begin
                    state_q <= ST_FIN;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Moves are younger than the finishing op, so they override the FIN write.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (in_fin & wen_q & ~flush) begin
                hi <= res_hi;
                lo <= res_lo;
            end
            if (mthi) hi <= mv_data;
            if (mtlo) lo <= mv_data;
        end
    end

endmodule

// File: doc/ex_hilo_muldiv.md
# ex_hilo_muldiv

Multi-cycle multiply/divide unit with the architectural HI/LO registers, in the EX stage directly downstream of the ID control decoder. It executes MULT/MULTU/DIV/DIVU and the 3-operand MUL, and services MTHI/MTLO. HI/LO are held as outputs for MFHI/MFLO. `busy` stalls the pipeline while an operation is in flight.

## Interface
- `MUL_CYCLES`, default 2: cycles spent in state MUL, valid range 1..4.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: launch request, sampled every cycle.
- `op_mul` in 1: multiply; driven from decoder alu select bit 2.
- `op_div` in 1: divide; driven from alu select bit 3. `op_mul` and `op_div` are never both 1.
- `op_signed` in 1: signed operation, equal to the inverse of `ctl_alu_op2`.
- `hilo_wen` in 1: commit the result to HI/LO. It is 0 for MUL.
- `src_a` in 32: rs_data, the multiplicand or dividend.
- `src_b` in 32: rt_data, the multiplier or divisor.
- `mthi` in 1, `mtlo` in 1: move-to-HI / move-to-LO strobes.
- `mv_data` in 32: rs_data for MTHI/MTLO.
- `flush` in 1: exception/ERET kill.
- `busy` out 1: pipeline stall request.
- `done` out 1: one-cycle result-valid pulse.
- `res_hi` out 32, `res_lo` out 32: raw result, valid only while `done`=1.
- `hi` out 32, `lo` out 32: architectural HI/LO registers.

## Operation
- States: IDLE, MUL, DIV, FIN.
- **Launch (IDLE only)**
  - The op is accepted when `start & (op_mul|op_div) & ~flush & ~mthi & ~mtlo`.
  - On accept, latch the operands, `op_signed` and `hilo_wen`.
  - `start` in any other state is ignored.
- **MUL**
  - Form the 64-bit product of the latched operands. Operands are sign-extended to 33 bits when signed and zero-extended otherwise.
  - A down-counter is loaded with MUL_CYCLES-1. Go to FIN when it reaches 0.
- **DIV**
  - Radix-2 restoring division on |a| and |b|; magnitudes are taken only when signed.
  - 32 iterations, one per cycle, using a 5-bit counter. Go to FIN after iteration 31.
  - Sign fix is applied in FIN:
    - quotient is negated if sign(a)^sign(b);
    - remainder is negated if sign(a).
- **Divide-by-zero** is not trapped and gives the algorithm's natural result:
  - unsigned: q=0xFFFFFFFF, r=a;
  - signed: r=a, q=1 if a<0, otherwise q=0xFFFFFFFF.
- **0x80000000 / -1 (signed)** gives q=0x80000000, r=0.
- **FIN**
  - `done`=1 and `res_hi`/`res_lo` are valid:
    - multiply: product[63:32] / [31:0];
    - divide: remainder / quotient.
  - If latched `hilo_wen`, HI/LO are written at the end of the cycle.
  - Next state is IDLE unconditionally.
- **MTHI/MTLO** write HI/LO from `mv_data` in any state. On a simultaneous FIN write to the same register, the move wins because it is the younger instruction.
- **flush**
  - In MUL or DIV: the next state is IDLE and nothing is written.
  - In FIN: the HI/LO write is suppressed and `done` is forced to 0.
- **busy** = (IDLE & launch accepted) | MUL | DIV. It is low in FIN, so EX advances with the result that cycle.

## Timing
- Reset values: state IDLE, `hi`=`lo`=0, `busy`=0, `done`=0, `res_hi`=`res_lo`=0, counters 0.
- Reset mid-operation aborts it. Reset has priority over flush, start and moves.
- Launch at cycle T:
  - MULT: FIN at T+MUL_CYCLES+1. HI/LO visible at T+MUL_CYCLES+2.
  - DIV: FIN at T+33. HI/LO visible at T+34.
- `busy` is high from T through FIN-1 inclusive; it depends combinationally on `start` at T.
- `hi`/`lo` are pure registers with no bypass. MFHI/MFLO read the registered value.
- Back-to-back: a new `start` is accepted in the cycle after FIN, which is IDLE. `start` in the FIN cycle itself is ignored.

## Structure
- Shared package:
  - state enum (IDLE/MUL/DIV/FIN);
  - `DIV_STEPS`=32;
  - `WORD_W`=32;
  - helper function `abs32`.
- One sub-module, `ex_div_iter`:
  - holds the remainder/quotient shift registers and the step counter;
  - interface: `load`, `step`, operands, `q`/`r` outputs;
  - sign handling stays in the parent.
- The multiply is inline. It is registered at FIN entry so synthesis can retime it across the MUL_CYCLES wait.

## Test plan
- MULT 0xFFFFFFFF × 2 signed → HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands as MULTU → HI=0x1, LO=0xFFFFFFFE. `done` at T+MUL_CYCLES+1 and `busy` low that cycle.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. `busy` high for exactly 33 cycles and `done` at T+33. DIVU 100/7 → LO=14, HI=2.
- DIVU 5/0 → LO=0xFFFFFFFF, HI=5. DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MUL 3×4 with `hilo_wen`=0 → `res_lo`=0xC, `res_hi`=0 with `done`=1, and HI/LO unchanged.
- `flush` in DIV iteration 10 → IDLE next cycle, `done` never asserts and HI/LO unchanged. A new `start` on the following cycle is accepted.
- `mthi` with 0x1234 in a MULT FIN cycle → HI=0x1234, LO=product low. `rst` mid-DIV → HI=LO=0, `busy`=0 next cycle.
